dff_pipeline_hs: RTL and testbench

//   Parametrised DEPTH-stage register pipeline for BITS-wide data, with a

---
 rtl/dff_pipeline_hs.sv | 84 ++++++++
 tb/tb_dff_pipeline_hs.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipeline_hs.sv
// dff_pipeline_hs: DEPTH-stage register pipeline with valid/ready handshake.
// Bubbles collapse under stall; flush clears every stage's valid bit.
module dff_pipeline_hs #(
  parameter int BITS  = 8,
  parameter int DEPTH = 3,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [BITS-1:0] out_data,
  input  logic            out_ready,
  output logic [CW-1:0]   occupancy
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_nxt;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_v;
  logic [DEPTH-1:0] ld;
  logic [BITS-1:0]  d    [DEPTH];
  logic [BITS-1:0]  up_d [DEPTH];
  logic [CW-1:0]    occ_nxt;

  // A stage may advance when it is empty or its successor advances.
  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = out_ready | ~v[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--)
      rdy[i] = rdy[i+1] | ~v[i];
  end

  always_comb begin
    up_v    = '0;
    up_v[0] = in_valid;
    up_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = v[i-1];
      up_d[i] = d[i-1];
    end
  end

  always_comb begin
    v_nxt = v;
    ld    = '0;
    if (flush) begin
      v_nxt = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) v_nxt[i] = up_v[i];
        ld[i] = rdy[i] & up_v[i];
      end
    end
  end

  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      occ_nxt = occ_nxt + CW'(v_nxt[i]);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      v         <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++)
        d[i] <= '0;
    end else begin
      v         <= v_nxt;
      occupancy <= occ_nxt;
      for (int i = 0; i < DEPTH; i++)
        if (ld[i]) d[i] <= up_d[i];
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v[DEPTH-1] & ~flush;
  assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_dff_pipeline_hs.sv
// tb_dff_pipeline_hs: directed checks of dff_pipeline_hs
// at DEPTH=3 and DEPTH=1 with hand-computed expectations.
module tb_dff_pipeline_hs;

  logic clk = 1'b0;
  logic reset_L;
  logic flush;
  always #5 clk = ~clk;

  logic       iv, ir, ov, ordy;
  logic [7:0] id, od;
  logic [1:0] occ;

  logic       iv1, ir1, ov1, ordy1;
  logic [7:0] id1, od1;
  logic       occ1;

  int total = 0;
  int bad   = 0;

  dff_pipeline_hs #(.BITS(8), .DEPTH(3)) u3 (
    .clk       (clk),
    .reset_L   (reset_L),
    .flush     (flush),
    .in_valid  (iv),
    .in_data   (id),
    .in_ready  (ir),
    .out_valid (ov),
    .out_data  (od),
    .out_ready (ordy),
    .occupancy (occ)
  );

  dff_pipeline_hs #(.BITS(8), .DEPTH(1)) u1 (
    .clk       (clk),
    .reset_L   (reset_L),
    .flush     (flush),
    .in_valid  (iv1),
    .in_data   (id1),
    .in_ready  (ir1),
    .out_valid (ov1),
    .out_data  (od1),
    .out_ready (ordy1),
    .occupancy (occ1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [7:0] d,
                     input logic r);
    iv   = v;
    id   = d;
    ordy = r;
    #1;
  endtask

  task automatic drv1(input logic v, input logic [7:0] d,
                      input logic r);
    iv1   = v;
    id1   = d;
    ordy1 = r;
    #1;
  endtask

  initial begin
    reset_L = 1'b0;
    flush   = 1'b0;
    iv = 0; id = 0; ordy = 0;
    iv1 = 0; id1 = 0; ordy1 = 0;
    #12;
    chk("rst_ov", ov, 0);
    chk("rst_occ", occ, 0);
    chk("rst_od", od, 0);
    chk("rst_ov1", ov1, 0);
    reset_L = 1'b1;
    #1;
    chk("rst_ir", ir, 1);
    chk("rst_ir1", ir1, 1);
    step();

    // streaming 0x01..0x0A with out_ready held high
    for (int k = 0; k < 14; k++) begin
      drv(k < 10, 8'(k + 1), 1'b1);
      if (k < 10) chk("s_rdy", ir, 1);
      chk("s_ov", ov, (k >= 3 && k <= 12));
      if (k >= 3 && k <= 12) chk("s_od", od, k - 2);
      if (k >= 3 && k <= 10) chk("s_occ", occ, 3);
      step();
    end
    chk("s_empty", occ, 0);

    // back-pressure
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 8'(8'hA1 + k), 1'b0);
      chk("bp_rdy", ir, 1);
      step();
    end
    for (int k = 0; k < 2; k++) begin
      drv(1'b1, 8'hA4, 1'b0);
      chk("bp_full", ir, 0);
      chk("bp_ov", ov, 1);
      chk("bp_od", od, 8'hA1);
      chk("bp_occ", occ, 3);
      step();
    end
    drv(1'b1, 8'hA4, 1'b1);
    chk("bp_rel_rdy", ir, 1);
    chk("bp_rel_od", od, 8'hA1);
    step();
    for (int k = 0; k < 3; k++) begin
      drv(1'b0, 8'h00, 1'b1);
      chk("bp_ov2", ov, 1);
      chk("bp_od2", od, 8'hA2 + k);
      step();
    end
    drv(1'b0, 8'h00, 1'b1);
    chk("bp_done", ov, 0);
    step();

    // bubble collapse
    drv(1'b1, 8'h11, 1'b0);
    step();
    drv(1'b0, 8'h00, 1'b0);
    step();
    step();
    drv(1'b1, 8'h22, 1'b0);
    step();
    drv(1'b0, 8'h00, 1'b0);
    step();
    step();
    chk("bb_occ", occ, 2);
    chk("bb_rdy", ir, 1);
    chk("bb_ov", ov, 1);
    chk("bb_od", od, 8'h11);
    drv(1'b0, 8'h00, 1'b1);
    step();
    chk("bb_od2", od, 8'h22);
    chk("bb_ov2", ov, 1);
    step();
    chk("bb_empty", ov, 0);

    // flush
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 8'(8'h31 + k), 1'b0);
      step();
    end
    chk("fl_occ0", occ, 3);
    flush = 1'b1;
    drv(1'b1, 8'h99, 1'b1);
    chk("fl_ov", ov, 0);
    chk("fl_rdy", ir, 0);
    step();
    flush = 1'b0;
    drv(1'b1, 8'h55, 1'b1);
    chk("fl_occ", occ, 0);
    chk("fl_ov2", ov, 0);
    chk("fl_rdy2", ir, 1);
    step();
    for (int k = 0; k < 2; k++) begin
      drv(1'b0, 8'h00, 1'b1);
      chk("fl_lat", ov, 0);
      step();
    end
    chk("fl_ov55", ov, 1);
    chk("fl_od55", od, 8'h55);
    step();

    // full with simultaneous in/out transfers
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 8'(8'h61 + k), 1'b0);
      step();
    end
    for (int k = 3; k < 11; k++) begin
      drv(k < 7, 8'(8'h61 + k), 1'b1);
      if (k < 7) chk("fs_rdy", ir, 1);
      chk("fs_ov", ov, k < 10);
      if (k < 10) chk("fs_od", od, 8'h61 + k - 3);
      if (k < 8) chk("fs_occ", occ, 3);
      step();
    end

    // DEPTH=1
    drv1(1'b1, 8'h71, 1'b0);
    chk("d1_rdy0", ir1, 1);
    step();
    drv1(1'b1, 8'h72, 1'b0);
    chk("d1_full", ir1, 0);
    chk("d1_ov", ov1, 1);
    chk("d1_occ", occ1, 1);
    chk("d1_od", od1, 8'h71);
    step();
    for (int k = 2; k < 8; k++) begin
      drv1(k < 6, 8'(8'h70 + k), 1'b1);
      if (k < 6) chk("d1s_rdy", ir1, 1);
      chk("d1s_ov", ov1, k < 7);
      if (k < 7) chk("d1s_od", od1, 8'h71 + k - 2);
      if (k < 7) chk("d1s_occ", occ1, 1);
      step();
    end
    chk("d1_empty", occ1, 0);

    // async reset with words in flight
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 8'(8'h81 + k), 1'b0);
      step();
    end
    drv(1'b0, 8'h00, 1'b0);
    chk("ar_occ0", occ, 3);
    #1;
    reset_L = 1'b0;
    #1;
    chk("ar_ov", ov, 0);
    chk("ar_occ", occ, 0);
    chk("ar_od", od, 0);
    #1;
    reset_L = 1'b1;
    #1;
    chk("ar_rdy", ir, 1);
    step();
    chk("ar_stay", ov, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
